// File: rtl/multicycle_controller.sv
// Control FSM for the RV32I multicycle core: sequences fetch, decode, execute,
// memory and writeback, raises a sticky trap on illegal encodings, counts retirements.
module multicycle_controller #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 N,
  input  logic                 Z,
  input  logic                 C,
  input  logic                 V,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 dmem_write,
  output logic                 adr_sel,
  output logic                 ir_write,
  output logic                 PC_write,
  output logic [1:0]           ALU_asel,
  output logic [1:0]           ALU_bsel,
  output logic [1:0]           result_sel,
  output logic [2:0]           ximm_sel,
  output logic [ALUCTRL_W-1:0] ALU_control,
  output logic                 regfile_wren,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instret
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_AUIPC    = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  logic [CNT_W-1:0] r_instret;
  logic             w_alu_supported;
  logic             w_branch_taken;
  logic             w_retire;
  logic [3:0]       w_alu_op;

  // funct7b5 picks sub only for register-register ops; for immediates it only picks sra.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic sub_ok);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    w_alu_supported = (ALUCTRL_W >= 4) || (funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);
  end

  // C is "no borrow" from rs1 - rs2, so C=1 means rs1 >= rs2 unsigned.
  always_comb begin
    case (funct3)
      3'b000:  w_branch_taken = Z;
      3'b001:  w_branch_taken = ~Z;
      3'b100:  w_branch_taken = N ^ V;
      3'b101:  w_branch_taken = ~(N ^ V);
      3'b110:  w_branch_taken = ~C;
      3'b111:  w_branch_taken = C;
      default: w_branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_REG:    w_next_state = w_alu_supported ? S_EXEC_R : S_TRAP;
          OP_IMM:    w_next_state = w_alu_supported ? S_EXEC_I : S_TRAP;
          OP_BRANCH: w_next_state = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          OP_JAL:    w_next_state = S_JAL;
          OP_JALR:   w_next_state = (funct3 == 3'b000) ? S_JALR : S_TRAP;
          OP_LUI:    w_next_state = S_LUI;
          OP_AUIPC:  w_next_state = S_AUIPC;
          default:   w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   w_next_state = S_ALUWB;
      S_EXEC_I:   w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JAL:      w_next_state = S_ALUWB;
      S_JALR:     w_next_state = S_JAL;
      S_LUI:      w_next_state = S_ALUWB;
      S_AUIPC:    w_next_state = S_ALUWB;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_TRAP;
    endcase
  end

  always_comb begin
    w_retire = (w_next_state == S_FETCH) &&
               ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                (r_state == S_ALUWB) || (r_state == S_BRANCH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mem_read     = 1'b0;
    dmem_write   = 1'b0;
    adr_sel      = 1'b0;
    ir_write     = 1'b0;
    PC_write     = 1'b0;
    ALU_asel     = A_PC;
    ALU_bsel     = B_RS2;
    result_sel   = 2'b00;
    ximm_sel     = IMM_I;
    regfile_wren = 1'b0;
    w_alu_op     = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        ALU_asel   = A_PC;
        ALU_bsel   = B_FOUR;
        result_sel = 2'b10;
        ir_write   = mem_ready;
        PC_write   = mem_ready;
      end
      S_DECODE: begin
        ALU_asel = A_OLDPC;
        ALU_bsel = B_IMM;
        ximm_sel = IMM_B;
      end
      S_MEMADR: begin
        ALU_asel = A_RS1;
        ALU_bsel = B_IMM;
        ximm_sel = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        adr_sel  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_sel   = 2'b01;
        regfile_wren = 1'b1;
      end
      S_MEMWRITE: begin
        adr_sel    = 1'b1;
        dmem_write = 1'b1;
      end
      S_EXEC_R: begin
        ALU_asel = A_RS1;
        ALU_bsel = B_RS2;
        w_alu_op = alu_decode(funct3, funct7b5, 1'b1);
      end
      S_EXEC_I: begin
        ALU_asel = A_RS1;
        ALU_bsel = B_IMM;
        ximm_sel = IMM_I;
        w_alu_op = alu_decode(funct3, funct7b5, 1'b0);
      end
      S_ALUWB: begin
        result_sel   = 2'b00;
        regfile_wren = 1'b1;
      end
      S_BRANCH: begin
        ALU_asel = A_RS1;
        ALU_bsel = B_RS2;
        w_alu_op = ALU_SUB;
        PC_write = w_branch_taken;
      end
      S_JAL: begin
        ximm_sel = IMM_J;
        ALU_asel = A_OLDPC;
        ALU_bsel = B_FOUR;
        PC_write = 1'b1;
      end
      S_JALR: begin
        ALU_asel = A_RS1;
        ALU_bsel = B_IMM;
        ximm_sel = IMM_I;
      end
      S_LUI: begin
        ALU_asel = A_ZERO;
        ALU_bsel = B_IMM;
        ximm_sel = IMM_U;
      end
      S_AUIPC: begin
        ALU_asel = A_OLDPC;
        ALU_bsel = B_IMM;
        ximm_sel = IMM_U;
      end
      default: begin
        w_alu_op = ALU_ADD;
      end
    endcase
  end

  // Ops needing the 4-bit encoding trap in decode, so truncation at width 3 is lossless.
  assign ALU_control = ALUCTRL_W'(w_alu_op);
  assign illegal     = (r_state == S_TRAP);
  assign instret     = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three configurations share stimulus; each
// instruction is checked against cycle counts and effects derived from the ISA rules.
module tb_multicycle_controller;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RR = 7'b0110011;
  localparam logic [6:0] RI = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] AU = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, N, Z, C, V, mem_ready;

  logic       mr_o [3];
  logic       dw_o [3];
  logic       adr_o [3];
  logic       irw_o [3];
  logic       pcw_o [3];
  logic       wren_o [3];
  logic       ill_o [3];
  logic [1:0] asel_o [3];
  logic [1:0] bsel_o [3];
  logic [1:0] rsel_o [3];
  logic [2:0] ximm_o [3];
  logic [2:0] alu_a;
  logic [3:0] alu_b, alu_c;
  logic [31:0] ins_a, ins_b;
  logic [3:0]  ins_c;

  multicycle_controller #(.ALUCTRL_W(3), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
    .mem_read(mr_o[0]), .dmem_write(dw_o[0]), .adr_sel(adr_o[0]), .ir_write(irw_o[0]),
    .PC_write(pcw_o[0]), .ALU_asel(asel_o[0]), .ALU_bsel(bsel_o[0]), .result_sel(rsel_o[0]),
    .ximm_sel(ximm_o[0]), .ALU_control(alu_a), .regfile_wren(wren_o[0]),
    .illegal(ill_o[0]), .instret(ins_a));

  multicycle_controller #(.ALUCTRL_W(4), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
    .mem_read(mr_o[1]), .dmem_write(dw_o[1]), .adr_sel(adr_o[1]), .ir_write(irw_o[1]),
    .PC_write(pcw_o[1]), .ALU_asel(asel_o[1]), .ALU_bsel(bsel_o[1]), .result_sel(rsel_o[1]),
    .ximm_sel(ximm_o[1]), .ALU_control(alu_b), .regfile_wren(wren_o[1]),
    .illegal(ill_o[1]), .instret(ins_b));

  multicycle_controller #(.ALUCTRL_W(4), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
    .mem_read(mr_o[2]), .dmem_write(dw_o[2]), .adr_sel(adr_o[2]), .ir_write(irw_o[2]),
    .PC_write(pcw_o[2]), .ALU_asel(asel_o[2]), .ALU_bsel(bsel_o[2]), .result_sel(rsel_o[2]),
    .ximm_sel(ximm_o[2]), .ALU_control(alu_c), .regfile_wren(wren_o[2]),
    .illegal(ill_o[2]), .instret(ins_c));

  logic [15:0] pk [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_pack
    assign pk[gi] = {mr_o[gi], dw_o[gi], adr_o[gi], irw_o[gi], pcw_o[gi], wren_o[gi],
                     ill_o[gi], asel_o[gi], bsel_o[gi], rsel_o[gi], ximm_o[gi]};
  end

  logic [1:0]  sel;
  logic [15:0] obs_pk;
  logic [3:0]  obs_alu;
  logic [31:0] obs_instret;
  logic        obs_mr, obs_dw, obs_adr, obs_irw, obs_pcw, obs_wren, obs_ill;
  logic [1:0]  obs_asel, obs_bsel, obs_rsel;
  logic [2:0]  obs_ximm;

  always_comb begin
    case (sel)
      2'd0:    begin obs_pk = pk[0]; obs_alu = {1'b0, alu_a}; obs_instret = ins_a; end
      2'd1:    begin obs_pk = pk[1]; obs_alu = alu_b; obs_instret = ins_b; end
      default: begin obs_pk = pk[2]; obs_alu = alu_c; obs_instret = {28'd0, ins_c}; end
    endcase
  end
  assign {obs_mr, obs_dw, obs_adr, obs_irw, obs_pcw, obs_wren, obs_ill,
          obs_asel, obs_bsel, obs_rsel, obs_ximm} = obs_pk;

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret;
  logic [31:0] cnt_mask;

  // ---------------- reference model ----------------
  function automatic int base_cycles(input logic [6:0] op);
    case (op)
      LD:      return 5;
      BR:      return 3;
      JR:      return 5;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7);
    if (op == BR) return 4'd1;
    if (op != RR && op != RI) return 4'd0;
    case (f3)
      3'd0:    return (op == RR && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    N = d[31];
    Z = (d == 32'd0);
    C = (a >= b);
    V = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  // ---------------- helpers ----------------
  task automatic tick(input logic mr);
    @(negedge clk);
    mem_ready = mr;
    #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    sel = s;
    cnt_mask = (s == 2'd2) ? 32'h0000_000f : 32'hffff_ffff;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    N = 1'b0; Z = 1'b0; C = 1'b0; V = 1'b0;
    #1;
    n_total++;
    if ({obs_mr, obs_adr, obs_irw, obs_bsel, obs_rsel, obs_ill} !== 8'b1_0_0_10_10_0 ||
        obs_instret !== 32'd0) begin
      n_bad++;
      $display("FAIL reset: got mr=%b adr=%b irw=%b bsel=%b rsel=%b ill=%b instret=%0d want 1 0 0 10 10 0 0",
               obs_mr, obs_adr, obs_irw, obs_bsel, obs_rsel, obs_ill, obs_instret);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 32'd0;
  endtask

  task automatic check_idle;
    tick(1'b0);
    n_total++;
    if (obs_instret !== exp_instret || obs_mr !== 1'b1 || obs_adr !== 1'b0) begin
      n_bad++;
      $display("FAIL idle: got instret=%0d mr=%b adr=%b want instret=%0d mr=1 adr=0",
               obs_instret, obs_mr, obs_adr, exp_instret);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b,
                           input int fw, input int mw);
    int total, mt, n_irw, irw_t, n_pcw, n_wren, wren_t, n_mem, n_frd, n_ill;
    int exp_pcw, exp_wren;
    logic isls;
    logic [1:0] wb_sel;
    isls = (op == LD) || (op == ST);
    total = base_cycles(op) + fw + (isls ? mw : 0);
    mt = fw + 3;
    opcode = op; funct3 = f3; funct7b5 = f7;
    set_flags(a, b);
    exp_pcw  = (op == JL || op == JR) ? 1 : (op == BR) ? int'(model_taken(f3, a, b)) : 0;
    exp_wren = (op == ST || op == BR) ? 0 : 1;
    n_irw = 0; irw_t = -1; n_pcw = 0; n_wren = 0; wren_t = -1; n_mem = 0; n_frd = 0; n_ill = 0;
    wb_sel = 2'b11;
    for (int t = 0; t < total; t++) begin
      logic mr;
      if (t < fw) mr = 1'b0;
      else if (t == fw) mr = 1'b1;
      else if (isls && t >= mt && t < mt + mw) mr = 1'b0;
      else if (isls && t == mt + mw) mr = 1'b1;
      else mr = 1'($urandom_range(1, 0));
      tick(mr);
      if (obs_irw) begin n_irw++; irw_t = t; end
      if (obs_pcw && t != fw) n_pcw++;
      if (obs_wren) begin n_wren++; wren_t = t; wb_sel = obs_rsel; end
      if (obs_mr && !obs_adr) n_frd++;
      if ((op == LD && obs_mr && obs_adr) || (op == ST && obs_dw)) n_mem++;
      if (obs_ill) n_ill++;
      if (t == 0 || t == total - 1) begin
        n_total++;
        if (obs_instret !== exp_instret) begin
          n_bad++;
          $display("FAIL instret_hold t=%0d: got %0d want %0d", t, obs_instret, exp_instret);
        end
      end
      if (t == fw + 1) begin
        n_total++;
        if ({obs_asel, obs_bsel, obs_ximm} !== 7'b01_01_010) begin
          n_bad++;
          $display("FAIL decode_mux: got asel=%b bsel=%b ximm=%b want 01 01 010",
                   obs_asel, obs_bsel, obs_ximm);
        end
      end
      if (t == fw + 2 && (op == RR || op == RI || op == BR)) begin
        n_total++;
        if (obs_alu !== model_alu(op, f3, f7)) begin
          n_bad++;
          $display("FAIL alu_ctrl op=%b f3=%b f7=%b: got %0d want %0d",
                   op, f3, f7, obs_alu, model_alu(op, f3, f7));
        end
      end
    end
    exp_instret = (exp_instret + 32'd1) & cnt_mask;
    n_total++;
    if (n_irw != 1 || irw_t != fw || n_frd != fw + 1) begin
      n_bad++;
      $display("FAIL fetch: got irw=%0d at %0d reads=%0d want 1 at %0d reads=%0d",
               n_irw, irw_t, n_frd, fw, fw + 1);
    end
    n_total++;
    if (n_mem != (isls ? mw + 1 : 0)) begin
      n_bad++;
      $display("FAIL mem_access: got %0d want %0d", n_mem, isls ? mw + 1 : 0);
    end
    n_total++;
    if (n_pcw != exp_pcw) begin
      n_bad++;
      $display("FAIL pc_write op=%b f3=%b: got %0d want %0d", op, f3, n_pcw, exp_pcw);
    end
    n_total++;
    if (n_wren != exp_wren || (exp_wren == 1 && (wren_t != total - 1 ||
        wb_sel !== ((op == LD) ? 2'b01 : 2'b00)))) begin
      n_bad++;
      $display("FAIL writeback: got n=%0d t=%0d sel=%b want n=%0d t=%0d sel=%b",
               n_wren, wren_t, wb_sel, exp_wren, total - 1, (op == LD) ? 2'b01 : 2'b00);
    end
    n_total++;
    if (n_ill != 0) begin
      n_bad++;
      $display("FAIL illegal_legal_instr: got %0d cycles want 0", n_ill);
    end
    $display("instr dut=%0d op=%b f3=%b f7=%b fw=%0d mw=%0d cycles=%0d instret=%0d",
             sel, op, f3, f7, fw, mw, total, exp_instret);
  endtask

  task automatic run_trap(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
    tick(1'b1);
    tick(1'($urandom_range(1, 0)));
    n_total++;
    if (obs_ill !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_early: got illegal=%b want 0", obs_ill);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'($urandom_range(1, 0)));
      n_total++;
      if (obs_ill !== 1'b1 || {obs_mr, obs_dw, obs_irw, obs_pcw, obs_wren} !== 5'd0 ||
          obs_instret !== exp_instret) begin
        n_bad++;
        $display("FAIL trap_hold i=%0d: got ill=%b en=%b instret=%0d want 1 00000 %0d", i,
                 obs_ill, {obs_mr, obs_dw, obs_irw, obs_pcw, obs_wren}, obs_instret,
                 exp_instret);
      end
    end
    $display("trap dut=%0d op=%b f3=%b f7=%b instret=%0d", sel, op, f3, f7, exp_instret);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      set_sel(2'(s));
      do_reset();
    end
  endtask

  task automatic test_rtype_add;
    set_sel(2'd0);
    do_reset();
    run_instr(RR, 3'b000, 1'b0, 32'd10, 32'd3, 0, 0);
    check_idle();
    n_total++;
    if (obs_instret !== 32'd1) begin
      n_bad++;
      $display("FAIL rtype_instret: got %0d want 1", obs_instret);
    end
  endtask

  task automatic test_load_waits;
    set_sel(2'd0);
    do_reset();
    run_instr(LD, 3'b010, 1'b0, 32'd0, 32'd0, 3, 3);
    run_instr(ST, 3'b010, 1'b0, 32'd0, 32'd0, 2, 4);
    check_idle();
  endtask

  task automatic test_branch;
    set_sel(2'd0);
    do_reset();
    run_instr(BR, 3'b100, 1'b0, 32'd1, 32'd5, 0, 0);
    run_instr(BR, 3'b100, 1'b0, 32'h7fff_ffff, 32'hffff_ffff, 0, 0);
    run_instr(BR, 3'b111, 1'b0, 32'd5, 32'd3, 1, 0);
    run_instr(BR, 3'b001, 1'b0, 32'd9, 32'd9, 0, 0);
    check_idle();
  endtask

  task automatic test_jalr;
    set_sel(2'd0);
    do_reset();
    run_instr(JR, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);
    check_idle();
    run_trap(JR, 3'b001, 1'b0);
  endtask

  task automatic test_alu_width;
    set_sel(2'd0);
    do_reset();
    run_trap(RR, 3'b100, 1'b0);
    set_sel(2'd1);
    do_reset();
    run_instr(RI, 3'b101, 1'b1, 32'd0, 32'd0, 0, 0);
    check_idle();
    run_trap(7'b1111111, 3'b000, 1'b0);
  endtask

  task automatic test_random;
    int brf3 [6] = '{0, 1, 4, 5, 6, 7};
    set_sel(2'd1);
    do_reset();
    for (int i = 0; i < 150; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(7, 0));
      f7 = 1'($urandom_range(1, 0));
      case ($urandom_range(7, 0))
        0: op = LD;
        1: op = ST;
        2: op = RR;
        3: op = RI;
        4: begin op = BR; f3 = 3'(brf3[$urandom_range(5, 0)]); end
        5: op = JL;
        6: begin op = JR; f3 = 3'd0; end
        default: op = ($urandom_range(1, 0) == 1) ? LU : AU;
      endcase
      a = $urandom;
      b = ($urandom_range(3, 0) == 0) ? a : $urandom;
      run_instr(op, f3, f7, a, b, $urandom_range(2, 0), $urandom_range(2, 0));
    end
    check_idle();
  endtask

  task automatic test_wrap_and_abort;
    set_sel(2'd2);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_instr(RI, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);
    end
    check_idle();
    n_total++;
    if (obs_instret !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap: got %0d want 0", obs_instret);
    end
    run_instr(RI, 3'b000, 1'b0, 32'd0, 32'd0, 0, 0);
    opcode = LD; funct3 = 3'b010;
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    n_total++;
    if (obs_mr !== 1'b1 || obs_adr !== 1'b1 || obs_instret !== 32'd1) begin
      n_bad++;
      $display("FAIL memread_pre_abort: got mr=%b adr=%b instret=%0d want 1 1 1",
               obs_mr, obs_adr, obs_instret);
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs_mr !== 1'b1 || obs_adr !== 1'b0 || obs_instret !== 32'd0 || obs_irw !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_reset: got mr=%b adr=%b instret=%0d irw=%b want 1 0 0 0",
               obs_mr, obs_adr, obs_instret, obs_irw);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 32'd0;
    $display("abort dut=%0d load reset during memory read instret=%0d", sel, obs_instret);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    N = 1'b0; Z = 1'b0; C = 1'b0; V = 1'b0;
    set_sel(2'd0);
    exp_instret = 32'd0;
    test_reset();
    test_rtype_add();
    test_load_waits();
    test_branch();
    test_jalr();
    test_alu_width();
    test_random();
    test_wrap_and_abort();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
